// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - 640x480@60 timing defaults, pattern select enum and colour-bar table
package vga_timing_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  typedef enum logic [1:0] {
    PAT_BARS  = 2'd0,
    PAT_CHECK = 2'd1,
    PAT_GRID  = 2'd2,
    PAT_EXT   = 2'd3
  } pattern_e;

  // {r,g,b} on/off per bar, index 0 is the leftmost bar (white) through 7 (black)
  localparam logic [7:0][2:0] BAR_RGB = {
    3'b000, 3'b001, 3'b100, 3'b101, 3'b010, 3'b011, 3'b110, 3'b111
  };

endpackage

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - one raster axis: wrapping count with sync and active region decode
module vga_axis_counter #(
  parameter int ACTIVE = 640,
  parameter int FP     = 16,
  parameter int SYNC   = 96,
  parameter int BP     = 48,
  parameter bit POL    = 1'b0,
  parameter int W      = $clog2(ACTIVE + FP + SYNC + BP)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_en,
  output logic [W-1:0] o_count,
  output logic         o_wrap,
  output logic         o_sync,
  output logic         o_active
);

  localparam int TOTAL      = ACTIVE + FP + SYNC + BP;
  localparam int SYNC_START = ACTIVE + FP;
  localparam int SYNC_END   = SYNC_START + SYNC;

  logic [W-1:0] r_count;
  logic         w_last;

  assign w_last = (r_count == W'(TOTAL - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= w_last ? '0 : r_count + W'(1);
    end
  end

  assign o_count  = r_count;
  assign o_wrap   = w_last;
  assign o_sync   = (r_count >= W'(SYNC_START) && r_count < W'(SYNC_END)) ? POL : ~POL;
  assign o_active = (r_count < W'(ACTIVE));

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing generator, two-stage output pipeline
// Optional built-in pattern source when VGA_PATTERN_EN is defined.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int  H_ACTIVE = DEF_H_ACTIVE,
  parameter int  H_FP     = DEF_H_FP,
  parameter int  H_SYNC   = DEF_H_SYNC,
  parameter int  H_BP     = DEF_H_BP,
  parameter int  V_ACTIVE = DEF_V_ACTIVE,
  parameter int  V_FP     = DEF_V_FP,
  parameter int  V_SYNC   = DEF_V_SYNC,
  parameter int  V_BP     = DEF_V_BP,
  parameter bit  HS_POL   = 1'b0,
  parameter bit  VS_POL   = 1'b0,
  parameter int  COLOR_W  = 1,
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int XW       = $clog2(H_TOTAL),
  localparam int YW       = $clog2(V_TOTAL)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic [1:0]             pat_sel,
  input  logic [3*COLOR_W-1:0]   rgb_in,
  output logic [XW-1:0]          x,
  output logic [YW-1:0]          y,
  output logic                   line_start,
  output logic                   frame_start,
  output logic                   hsync,
  output logic                   vsync,
  output logic                   de,
  output logic [COLOR_W-1:0]     red,
  output logic [COLOR_W-1:0]     green,
  output logic [COLOR_W-1:0]     blue
);

  if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
      V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_zero_param
    $error("vga_timing_gen: every timing parameter must be non-zero");
  end
  if (H_ACTIVE % 8 != 0) begin : g_bad_h_active
    $error("vga_timing_gen: H_ACTIVE must be a multiple of 8");
  end

  logic [XW-1:0] w_h;
  logic [YW-1:0] w_v;
  logic          w_h_wrap, w_v_wrap;
  logic          w_hs, w_vs, w_h_act, w_v_act;

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(HS_POL), .W(XW)
  ) u_h_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_en     (en),
    .o_count  (w_h),
    .o_wrap   (w_h_wrap),
    .o_sync   (w_hs),
    .o_active (w_h_act)
  );

  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(VS_POL), .W(YW)
  ) u_v_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_en     (en && w_h_wrap),
    .o_count  (w_v),
    .o_wrap   (w_v_wrap),
    .o_sync   (w_vs),
    .o_active (w_v_act)
  );

  // Flags track "counters sit at x==0" / "at (0,0)" so stage 1 avoids wide compares
  logic r_h_zero, r_origin;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h_zero <= 1'b1;
      r_origin <= 1'b1;
    end else if (en) begin
      r_h_zero <= w_h_wrap;
      r_origin <= w_h_wrap && w_v_wrap;
    end
  end

  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic          r_line_start, r_frame_start;
  logic          r_hs1, r_vs1, r_de1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x           <= '0;
      r_y           <= '0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
      r_hs1         <= ~HS_POL;
      r_vs1         <= ~VS_POL;
      r_de1         <= 1'b0;
    end else if (en) begin
      r_x           <= w_h;
      r_y           <= w_v;
      r_line_start  <= r_h_zero;
      r_frame_start <= r_origin;
      r_hs1         <= w_hs;
      r_vs1         <= w_vs;
      r_de1         <= w_h_act && w_v_act;
    end
  end

  logic [3*COLOR_W-1:0] w_colour;

`ifdef VGA_PATTERN_EN
  localparam int BAR_W = H_ACTIVE / 8;

  pattern_e   r_pat, w_pat;
  logic [2:0] w_bar_idx, w_bar;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pat <= PAT_BARS;
    end else if (r_frame_start) begin
      r_pat <= pattern_e'(pat_sel);
    end
  end

  // The first pixel of a frame already uses the selection being latched
  assign w_pat     = r_frame_start ? pattern_e'(pat_sel) : r_pat;
  assign w_bar_idx = 3'(r_x / XW'(BAR_W));
  assign w_bar     = BAR_RGB[w_bar_idx];

  always_comb begin
    w_colour = '0;
    case (w_pat)
      PAT_BARS:  w_colour = {{COLOR_W{w_bar[2]}}, {COLOR_W{w_bar[1]}}, {COLOR_W{w_bar[0]}}};
      PAT_CHECK: w_colour = (((32'(r_x) ^ 32'(r_y)) & 32'h20) != 32'h0) ? '1 : '0;
      PAT_GRID:  w_colour = (((32'(r_x) & 32'h3f) == 32'h0) ||
                             ((32'(r_y) & 32'h3f) == 32'h0)) ? '1 : '0;
      default:   w_colour = rgb_in;
    endcase
  end
`else
  // pat_sel has no function without the pattern source
  logic w_pat_sel_unused;
  assign w_pat_sel_unused = ^pat_sel;
  assign w_colour         = rgb_in;
`endif

  logic                 r_hsync, r_vsync, r_de;
  logic [3*COLOR_W-1:0] r_rgb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hsync <= ~HS_POL;
      r_vsync <= ~VS_POL;
      r_de    <= 1'b0;
      r_rgb   <= '0;
    end else if (!en) begin
      r_hsync <= ~HS_POL;
      r_vsync <= ~VS_POL;
      r_de    <= 1'b0;
      r_rgb   <= '0;
    end else begin
      r_hsync <= r_hs1;
      r_vsync <= r_vs1;
      r_de    <= r_de1;
      r_rgb   <= r_de1 ? w_colour : '0;
    end
  end

  assign x           = r_x;
  assign y           = r_y;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign de          = r_de;
  assign red         = r_rgb[3*COLOR_W-1 -: COLOR_W];
  assign green       = r_rgb[2*COLOR_W-1 -: COLOR_W];
  assign blue        = r_rgb[COLOR_W-1:0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - randomized bench for vga_timing_gen against a raster-position model
module tb_vga_timing_gen;

  localparam int NI = 2;
  localparam int HA  [NI] = '{80, 24};
  localparam int HF  [NI] = '{4, 3};
  localparam int HS  [NI] = '{6, 4};
  localparam int HB  [NI] = '{6, 5};
  localparam int VA  [NI] = '{66, 5};
  localparam int VF  [NI] = '{3, 2};
  localparam int VS  [NI] = '{2, 1};
  localparam int VB  [NI] = '{4, 3};
  localparam int POL [NI] = '{0, 1};
  localparam int CW  [NI] = '{1, 2};
  localparam int A_XW = $clog2(80 + 4 + 6 + 6);
  localparam int A_YW = $clog2(66 + 3 + 2 + 4);
  localparam int B_XW = $clog2(24 + 3 + 4 + 5);
  localparam int B_YW = $clog2(5 + 2 + 1 + 3);
`ifdef VGA_PATTERN_EN
  localparam bit PAT_EN = 1'b1;
`else
  localparam bit PAT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [1:0] pat_sel = 2'd0;

  logic [A_XW-1:0] a_x;
  logic [A_YW-1:0] a_y;
  logic a_ls, a_fs, a_hsync, a_vsync, a_de;
  logic [0:0] a_red, a_green, a_blue;
  logic [2:0] a_rgb_in;
  logic [B_XW-1:0] b_x;
  logic [B_YW-1:0] b_y;
  logic b_ls, b_fs, b_hsync, b_vsync, b_de;
  logic [1:0] b_red, b_green, b_blue;
  logic [5:0] b_rgb_in;
  int a_src, b_src;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_ACTIVE(HA[0]), .H_FP(HF[0]), .H_SYNC(HS[0]), .H_BP(HB[0]),
    .V_ACTIVE(VA[0]), .V_FP(VF[0]), .V_SYNC(VS[0]), .V_BP(VB[0]),
    .HS_POL(1'b0), .VS_POL(1'b0), .COLOR_W(1)
  ) u_dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .pat_sel(pat_sel), .rgb_in(a_rgb_in),
    .x(a_x), .y(a_y), .line_start(a_ls), .frame_start(a_fs),
    .hsync(a_hsync), .vsync(a_vsync), .de(a_de),
    .red(a_red), .green(a_green), .blue(a_blue)
  );

  vga_timing_gen #(
    .H_ACTIVE(HA[1]), .H_FP(HF[1]), .H_SYNC(HS[1]), .H_BP(HB[1]),
    .V_ACTIVE(VA[1]), .V_FP(VF[1]), .V_SYNC(VS[1]), .V_BP(VB[1]),
    .HS_POL(1'b1), .VS_POL(1'b1), .COLOR_W(2)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .pat_sel(pat_sel), .rgb_in(b_rgb_in),
    .x(b_x), .y(b_y), .line_start(b_ls), .frame_start(b_fs),
    .hsync(b_hsync), .vsync(b_vsync), .de(b_de),
    .red(b_red), .green(b_green), .blue(b_blue)
  );

  function automatic int htot(input int i);
    return HA[i] + HF[i] + HS[i] + HB[i];
  endfunction

  function automatic int vtot(input int i);
    return VA[i] + VF[i] + VS[i] + VB[i];
  endfunction

  // Upstream pixel source: colour is a fixed function of the pixel coordinate
  function automatic int src_rgb(input int i, input int px, input int py);
    return (px * 5 + py * 3 + i) & ((1 << (3 * CW[i])) - 1);
  endfunction

  assign a_src    = src_rgb(0, int'(a_x), int'(a_y));
  assign b_src    = src_rgb(1, int'(b_x), int'(b_y));
  assign a_rgb_in = a_src[2:0];
  assign b_rgb_in = b_src[5:0];

  function automatic int colour(input int i, input int h, input int v, input int p);
    int bars [8] = '{7, 6, 3, 2, 5, 4, 1, 0};
    int full = (1 << CW[i]) - 1;
    int w;
    if (!PAT_EN || p == 3) return src_rgb(i, h, v);
    case (p)
      0:       w = bars[h / (HA[i] / 8)];
      1:       w = (((h >> 5) ^ (v >> 5)) & 1) != 0 ? 7 : 0;
      default: w = (h % 64 == 0 || v % 64 == 0) ? 7 : 0;
    endcase
    return ((((w >> 2) & 1) != 0) ? (full << (2 * CW[i])) : 0) |
           ((((w >> 1) & 1) != 0) ? (full << CW[i]) : 0) |
           (((w & 1) != 0) ? full : 0);
  endfunction

  int cnt [NI];
  int s1_pos [NI];
  bit s1_vld [NI];
  int pat [NI];
  int pin [NI][4];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic set_idle(input int i);
    pin[i][0] = 1 - POL[i];
    pin[i][1] = 1 - POL[i];
    pin[i][2] = 0;
    pin[i][3] = 0;
  endtask

  task automatic set_pixel(input int i, input int pos);
    int h, v;
    h = pos % htot(i);
    v = pos / htot(i);
    pin[i][0] = (h >= HA[i] + HF[i] && h < HA[i] + HF[i] + HS[i]) ? POL[i] : 1 - POL[i];
    pin[i][1] = (v >= VA[i] + VF[i] && v < VA[i] + VF[i] + VS[i]) ? POL[i] : 1 - POL[i];
    pin[i][2] = (h < HA[i] && v < VA[i]) ? 1 : 0;
    pin[i][3] = (pin[i][2] != 0) ? colour(i, h, v, pat[i]) : 0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      cnt[i] = 0;
      s1_pos[i] = 0;
      s1_vld[i] = 1'b0;
      pat[i] = 0;
      set_idle(i);
    end
  endtask

  // Raster position advances per enabled clock; x/y show it one clock later, pins two
  task automatic model_step();
    for (int i = 0; i < NI; i++) begin
      if (s1_vld[i] && s1_pos[i] == 0) pat[i] = int'(pat_sel);
      if (en) begin
        if (s1_vld[i]) set_pixel(i, s1_pos[i]);
        else set_idle(i);
        s1_pos[i] = cnt[i];
        s1_vld[i] = 1'b1;
        cnt[i] = (cnt[i] + 1) % (htot(i) * vtot(i));
      end else begin
        set_idle(i);
      end
    end
  endtask

  function automatic string fname(input int k);
    case (k)
      0: return "x";
      1: return "y";
      2: return "line_start";
      3: return "frame_start";
      4: return "hsync";
      5: return "vsync";
      6: return "de";
      default: return "rgb";
    endcase
  endfunction

  task automatic compare_all();
    int o [NI][8];
    int e [8];
    o[0][0] = int'(a_x);     o[1][0] = int'(b_x);
    o[0][1] = int'(a_y);     o[1][1] = int'(b_y);
    o[0][2] = int'(a_ls);    o[1][2] = int'(b_ls);
    o[0][3] = int'(a_fs);    o[1][3] = int'(b_fs);
    o[0][4] = int'(a_hsync); o[1][4] = int'(b_hsync);
    o[0][5] = int'(a_vsync); o[1][5] = int'(b_vsync);
    o[0][6] = int'(a_de);    o[1][6] = int'(b_de);
    o[0][7] = int'({a_red, a_green, a_blue});
    o[1][7] = int'({b_red, b_green, b_blue});
    for (int i = 0; i < NI; i++) begin
      e[0] = s1_pos[i] % htot(i);
      e[1] = s1_pos[i] / htot(i);
      e[2] = (s1_vld[i] && e[0] == 0) ? 1 : 0;
      e[3] = (s1_vld[i] && s1_pos[i] == 0) ? 1 : 0;
      for (int k = 0; k < 4; k++) e[4 + k] = pin[i][k];
      for (int k = 0; k < 8; k++)
        check($sformatf("%s.%s", (i == 0) ? "A" : "B", fname(k)), o[i][k], e[k]);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst_n) model_step();
    else model_reset();
    @(negedge clk);
    compare_all();
  endtask

  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    #1 model_reset();
    compare_all();
    repeat (3) cycle();
    rst_n = 1'b1;
  endtask

  int fta, ftb;
  int first_hs_a, first_hs_b, de_a, hs_a, vs_a, de_b;
  int fs1, fs2, ls1, ls2, pause;
  int sched [8] = '{1, 2, 0, 3, 2, 1, 0, 3};

  initial begin
    fta = htot(0) * vtot(0);
    ftb = htot(1) * vtot(1);
    first_hs_a = -1; first_hs_b = -1;
    de_a = 0; hs_a = 0; vs_a = 0; de_b = 0;
    fs1 = -1; fs2 = -1; ls1 = -1; ls2 = -1;
    pause = 0;
    model_reset();
    repeat (3) cycle();

    rst_n = 1'b1;
    en = 1'b1;
    for (int e = 1; e <= 2 * fta + 4; e++) begin
      cycle();
      if (first_hs_a < 0 && int'(a_hsync) == POL[0]) first_hs_a = e;
      if (first_hs_b < 0 && int'(b_hsync) == POL[1]) first_hs_b = e;
      if (e <= fta + 1) begin
        de_a += int'(a_de);
        hs_a += (int'(a_hsync) == POL[0]) ? 1 : 0;
        vs_a += (int'(a_vsync) == POL[0]) ? 1 : 0;
      end
      if (e <= ftb + 1) de_b += int'(b_de);
      if (a_fs) begin
        if (fs1 < 0) fs1 = e;
        else if (fs2 < 0) fs2 = e;
      end
      if (a_ls) begin
        if (ls1 < 0) ls1 = e;
        else if (ls2 < 0) ls2 = e;
      end
    end
    check("A.first_hsync_edge", first_hs_a, 2 + HA[0] + HF[0]);
    check("B.first_hsync_edge", first_hs_b, 2 + HA[1] + HF[1]);
    check("A.de_per_frame", de_a, HA[0] * VA[0]);
    check("A.hsync_per_frame", hs_a, vtot(0) * HS[0]);
    check("A.vsync_per_frame", vs_a, VS[0] * htot(0));
    check("B.de_per_frame", de_b, HA[1] * VA[1]);
    check("A.first_frame_start", fs1, 1);
    check("A.frame_period", fs2 - fs1, fta);
    check("A.line_period", ls2 - ls1, htot(0));

    for (int c = 0; c < 24000; c++) begin
      if (pause > 0) begin
        en = 1'b0;
        pause--;
      end else begin
        en = 1'b1;
        if ($urandom_range(0, 399) == 0) pause = $urandom_range(1, 100);
      end
      if (c % 2500 == 1200) pat_sel = 2'(sched[(c / 2500) % 8]);
      cycle();
      if (c == 9000 || $urandom_range(0, 9999) == 0) pulse_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
